// File: rtl/ps2_key_event_fifo.sv
// PS/2 receiver + E0/F0 decoder + repeat filter feeding an event FIFO. Stop-bit fe at N -> ev_valid at N+2.
// Backpressure: events wait in the FIFO until ev_ready; a push into a full FIFO without a pop is dropped and flags overflow.

module ps2_key_event_fifo_buf #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     push_vld_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_rdy_i,
    output logic                     pop_vld_o,
    output logic [W-1:0]             pop_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          wr_en, rd_en;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign pop_vld_o = (count_q != '0);
    assign rd_en     = pop_rdy_i & pop_vld_o;
    assign wr_en     = push_vld_i & (~full_o | rd_en);
    assign count_o   = count_q;
    // Gated so the data port reads zero while empty, including straight out of reset.
    assign pop_dat_o = pop_vld_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_en && !rd_en)      count_q <= count_q + (AW+1)'(1);
            else if (rd_en && !wr_en) count_q <= count_q - (AW+1)'(1);
        end
    end
endmodule

module ps2_key_event_fifo #(
    parameter int DEPTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int TIMEOUT_CYC   = 50000,
    parameter int FILTER_REPEAT = 1
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     PS2_CLK,
    input  logic                     PS2_DAT,
    input  logic                     ev_ready,
    output logic                     ev_valid,
    output logic [9:0]               ev_data,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     overflow,
    output logic                     parity_err,
    output logic                     frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_prev_q, clk_s, dat_s, fe;

    rx_state_t state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_rdy_q, byte_rdy_d;
    logic          perr_q, perr_d, ferr_q, ferr_d;

    logic       ext_q, ext_d, rel_q, rel_d;
    logic       held_vld_q, held_vld_d;
    logic [8:0] held_key_q, held_key_d;
    logic       push_vld;
    logic       fifo_full, pop;
    logic       overflow_q;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fe    = clk_prev_q & ~clk_s;

    // Synchronisers reset high (idle bus) so reset release never fakes a falling edge.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
            clk_prev_q <= clk_s;
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            byte_rdy_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            byte_rdy_q <= byte_rdy_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = '0;
        byte_rdy_d = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        if (state_q != IDLE && !fe) tmo_d = tmo_q + TW'(1);
        case (state_q)
            IDLE: if (fe && !dat_s) begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: if (fe) begin
                shift_d   = {dat_s, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (fe) begin
                par_d   = dat_s;
                state_d = STOP;
            end
            STOP: if (fe) begin
                state_d = IDLE;
                if (!dat_s)                     ferr_d     = 1'b1;
                else if (!(^{shift_q, par_q}))  perr_d     = 1'b1;
                else                            byte_rdy_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !fe && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
        end
    end

    // Decoder and typematic filter; held tracks the last pushed make as {ext, code}.
    always_comb begin
        ext_d      = ext_q;
        rel_d      = rel_q;
        held_vld_d = held_vld_q;
        held_key_d = held_key_q;
        push_vld   = 1'b0;
        if (perr_q || ferr_q) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end else if (byte_rdy_q) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
                rel_d = rel_q;
            end else if (shift_q == 8'hF0) begin
                ext_d = ext_q;
                rel_d = 1'b1;
            end else if (shift_q != 8'h00 && shift_q != 8'hFF) begin
                if (rel_q) begin
                    push_vld = 1'b1;
                    if (held_vld_q && held_key_q == {ext_q, shift_q}) held_vld_d = 1'b0;
                end else if (!(FILTER_REPEAT != 0 && held_vld_q && held_key_q == {ext_q, shift_q})) begin
                    push_vld   = 1'b1;
                    held_vld_d = 1'b1;
                    held_key_d = {ext_q, shift_q};
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            held_vld_q <= 1'b0;
            held_key_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            held_vld_q <= held_vld_d;
            held_key_q <= held_key_d;
            if (push_vld && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    assign pop = ev_valid & ev_ready;

    ps2_key_event_fifo_buf #(.W(10), .DEPTH(DEPTH)) u_buf (
        .CLK        (CLK),
        .rst        (rst),
        .push_vld_i (push_vld),
        .push_dat_i ({ext_q, rel_q, shift_q}),
        .pop_rdy_i  (ev_ready),
        .pop_vld_o  (ev_valid),
        .pop_dat_o  (ev_data),
        .count_o    (ev_count),
        .full_o     (fifo_full)
    );

    assign overflow   = overflow_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Scoreboard bench: a keyboard-level model predicts events per frame; a negedge monitor checks every pop.
module tb_ps2_key_event_fifo;
    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int H     = 6;

    logic CLK = 0, rst = 0, PS2_CLK = 1, PS2_DAT = 1;
    logic rdy_tb = 0, rdy_rand = 0, rand_en = 0;
    logic ev_ready, ev_valid, overflow, parity_err, frame_err;
    logic [9:0] ev_data;
    logic [$clog2(DEPTH):0] ev_count;

    int n_chk = 0, n_fail = 0, cyc = 0, last_fe_cyc = 0;
    logic [9:0] exp_q[$];
    bit m_ext = 0, m_rel = 0, m_held_vld = 0, m_ovf = 0;
    logic [8:0] m_held = '0;

    assign ev_ready = rand_en ? rdy_rand : rdy_tb;

    ps2_key_event_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO), .FILTER_REPEAT(1)) dut (
        .CLK(CLK), .rst(rst), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT), .ev_ready(ev_ready),
        .ev_valid(ev_valid), .ev_data(ev_data), .ev_count(ev_count), .overflow(overflow),
        .parity_err(parity_err), .frame_err(frame_err));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;
    initial forever begin
        @(posedge CLK); #1;
        rdy_rand = 1'($urandom_range(0, 1));
    end

    always @(negedge CLK) begin
        if (rst && ev_valid && ev_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop: got event %h, required none", ev_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (ev_data !== e) begin
                    n_fail++;
                    $display("FAIL pop: got %h, required %h", ev_data, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic model_push(input logic [9:0] ev);
        if (exp_q.size() >= DEPTH && !ev_ready) m_ovf = 1;
        else exp_q.push_back(ev);
    endtask

    // Keyboard view: prefixes set flags, other bytes become events, the held make suppresses repeats.
    task automatic model_byte(input logic [7:0] b, input bit ok);
        logic [8:0] key;
        key = {m_ext, b};
        if (!ok) begin
            m_ext = 0; m_rel = 0;
        end else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_rel = 1;
        else begin
            if (b != 8'h00 && b != 8'hFF) begin
                if (m_rel) begin
                    model_push({m_ext, m_rel, b});
                    if (m_held_vld && m_held == key) m_held_vld = 0;
                end else if (!(m_held_vld && m_held == key)) begin
                    model_push({m_ext, m_rel, b});
                    m_held_vld = 1; m_held = key;
                end
            end
            m_ext = 0; m_rel = 0;
        end
    endtask

    task automatic ps2_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits, input bit pulse_rdy, input bit chk_lat);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = fr[i];
            repeat (H) @(posedge CLK); #1;
            PS2_CLK = 0;
            last_fe_cyc = cyc;
            if (i == 10) begin
                repeat (3) @(posedge CLK); #1;
                chk("parity_err_pulse", int'(parity_err), int'(bad_par && !bad_stop));
                chk("frame_err_pulse", int'(frame_err), int'(bad_stop));
                if (chk_lat) chk("valid_at_n1", int'(ev_valid), 0);
                if (pulse_rdy) rdy_tb = 1;
                @(posedge CLK); #1;
                if (pulse_rdy) rdy_tb = 0;
                chk("err_pulse_end", int'(parity_err | frame_err), 0);
                if (chk_lat) chk("valid_at_n2", int'(ev_valid), 1);
                model_byte(b, !bad_par && !bad_stop);
                repeat (H - 4) @(posedge CLK); #1;
            end else begin
                repeat (H) @(posedge CLK); #1;
            end
            PS2_CLK = 1;
        end
        PS2_DAT = 1;
    endtask

    task automatic send(input logic [7:0] b);
        ps2_frame(b, 0, 0, 11, 0, 0);
    endtask

    task automatic drain();
        int n;
        rdy_tb = 1;
        n = 0;
        while (ev_valid && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("drain_timeout", int'(ev_valid), 0);
        chk("drain_expected_left", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        logic [7:0] pool[5];
        pool[0] = 8'h1C; pool[1] = 8'h75; pool[2] = 8'h6B; pool[3] = 8'h72; pool[4] = 8'h29;

        repeat (3) @(posedge CLK); #1;
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_count", int'(ev_count), 0);
        chk("rst_data", int'(ev_data), 0);
        chk("rst_flags", int'({overflow, parity_err, frame_err}), 0);
        rst = 1;
        repeat (3) @(posedge CLK); #1;

        // Single make with the consumer stalled, checking the N+2 latency.
        ps2_frame(8'h75, 0, 0, 11, 0, 1);
        chk("t1_data", int'(ev_data), 'h075);
        chk("t1_count", int'(ev_count), 1);
        drain();

        // Typematic repeats collapse to one make.
        rdy_tb = 1;
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        drain();

        // Extended break, then a plain make.
        send(8'hE0); send(8'hF0); send(8'h6B); send(8'h1C);
        drain();

        // Bad parity / bad stop discard the byte.
        rdy_tb = 0;
        ps2_frame(8'h75, 1, 0, 11, 0, 0);
        ps2_frame(8'h75, 0, 1, 11, 0, 0);
        chk("t5_no_event", int'(ev_valid), 0);

        // Overflow, then push and pop in the same cycle while full.
        for (int i = 0; i <= DEPTH; i++) send(8'h30 + 8'(i));
        chk("t4_count_full", int'(ev_count), DEPTH);
        chk("t4_overflow", int'(overflow), int'(m_ovf));
        chk("t4_overflow_set", int'(overflow), 1);
        ps2_frame(8'h4A, 0, 0, 11, 1, 0);
        chk("t4_count_pushpop", int'(ev_count), DEPTH);
        drain();

        // Randomised traffic with a randomly stalling consumer.
        rand_en = 1;
        for (int k = 0; k < 50; k++) begin
            int r;
            r = $urandom_range(0, 15);
            case (r)
                0: send(8'hE0);
                1, 2: send(8'hF0);
                3: send(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
                4: ps2_frame(pool[$urandom_range(0, 4)], 1, 0, 11, 0, 0);
                5: ps2_frame(pool[$urandom_range(0, 4)], 0, 1, 11, 0, 0);
                6: send(8'($urandom_range(1, 'hDF)));
                default: send(pool[$urandom_range(0, 4)]);
            endcase
        end
        rand_en = 0;
        drain();
        chk("rand_overflow", int'(overflow), int'(m_ovf));

        // Timeout abort clears a pending F0.
        send(8'hF0);
        ps2_frame(8'h00, 0, 0, 5, 0, 0);
        n = 0;
        while (!frame_err && n < TMO + 50) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("t6_timeout_seen", int'(frame_err), 1);
        chk("t6_timeout_window", int'((cyc - last_fe_cyc) >= TMO && (cyc - last_fe_cyc) <= TMO + 4), 1);
        m_ext = 0; m_rel = 0;
        send(8'h72);
        drain();

        // Reset mid-frame with events queued.
        rdy_tb = 0;
        send(8'h11); send(8'h12);
        ps2_frame(8'h55, 0, 0, 3, 0, 0);
        @(posedge CLK); #1;
        rst = 0;
        #2;
        chk("mid_rst_valid", int'(ev_valid), 0);
        chk("mid_rst_count", int'(ev_count), 0);
        chk("mid_rst_data", int'(ev_data), 0);
        chk("mid_rst_flags", int'({overflow, parity_err, frame_err}), 0);
        exp_q.delete();
        m_ext = 0; m_rel = 0; m_held_vld = 0; m_ovf = 0;
        repeat (3) @(posedge CLK); #1;
        rst = 1;
        repeat (3) @(posedge CLK); #1;
        rdy_tb = 1;
        send(8'h72);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
